// File: rtl/vaddr_adder_arbiter.sv
// vaddr_adder_arbiter: shares one vaddr adder between LB and SB.
// Round-robin grant, sticky while stalled, results steered by is_store.
package lsu_pkg;
  typedef logic [3:0] except_code_t;
endpackage

module vaddr_adder_arbiter
  import lsu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int LB_IDX_LEN    = 3,
  parameter int SB_IDX_LEN    = 3,
  parameter int LDST_TYPE_LEN = 3,
  parameter int IDX_LEN       = (LB_IDX_LEN > SB_IDX_LEN) ?
                                LB_IDX_LEN : SB_IDX_LEN
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     lb_valid_i,
  output logic                     lb_ready_o,
  input  logic [XLEN-1:0]          lb_rs1_value_i,
  input  logic [XLEN-1:0]          lb_imm_value_i,
  input  logic [LB_IDX_LEN-1:0]    lb_idx_i,
  input  logic [LDST_TYPE_LEN-1:0] lb_ldst_type_i,
  input  logic                     sb_valid_i,
  output logic                     sb_ready_o,
  input  logic [XLEN-1:0]          sb_rs1_value_i,
  input  logic [XLEN-1:0]          sb_imm_value_i,
  input  logic [SB_IDX_LEN-1:0]    sb_idx_i,
  input  logic [LDST_TYPE_LEN-1:0] sb_ldst_type_i,
  output logic                     adder_valid_o,
  input  logic                     adder_ready_i,
  output logic                     adder_is_store_o,
  output logic [XLEN-1:0]          adder_rs1_o,
  output logic [XLEN-1:0]          adder_imm_o,
  output logic [IDX_LEN-1:0]       adder_idx_o,
  output logic [LDST_TYPE_LEN-1:0] adder_ldst_type_o,
  input  logic                     adder_res_valid_i,
  output logic                     adder_res_ready_o,
  input  logic                     adder_is_store_i,
  input  logic [XLEN-1:0]          adder_vaddr_i,
  input  logic [IDX_LEN-1:0]       adder_idx_i,
  input  except_code_t             adder_except_i,
  output logic                     lb_res_valid_o,
  output logic                     sb_res_valid_o,
  input  logic                     lb_res_ready_i,
  input  logic                     sb_res_ready_i,
  output logic [XLEN-1:0]          res_vaddr_o,
  output logic [IDX_LEN-1:0]       res_idx_o,
  output except_code_t             res_except_o
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_LB,
    HOLD_SB
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   gnt_lb, gnt_sb;
  logic   go, xfer, rsel;

  // Pick requester: sticky in HOLD_x, else single valid or prio on tie.
  always_comb begin
    gnt_lb = 1'b0;
    gnt_sb = 1'b0;
    unique case (state_q)
      HOLD_LB: gnt_lb = lb_valid_i;
      HOLD_SB: gnt_sb = sb_valid_i;
      default: begin
        if (lb_valid_i && sb_valid_i) begin
          gnt_sb = prio_q;
          gnt_lb = !prio_q;
        end else begin
          gnt_lb = lb_valid_i;
          gnt_sb = sb_valid_i;
        end
      end
    endcase
  end

  // Handshake outputs and operand mux; quiet while reset or flush.
  always_comb begin
    go                = rst_n_i & ~flush_i;
    adder_valid_o     = go & (gnt_lb | gnt_sb);
    adder_is_store_o  = go & gnt_sb;
    xfer              = adder_valid_o & adder_ready_i;
    lb_ready_o        = go & gnt_lb & adder_ready_i;
    sb_ready_o        = go & gnt_sb & adder_ready_i;
    adder_rs1_o       = gnt_sb ? sb_rs1_value_i : lb_rs1_value_i;
    adder_imm_o       = gnt_sb ? sb_imm_value_i : lb_imm_value_i;
    adder_ldst_type_o = gnt_sb ? sb_ldst_type_i : lb_ldst_type_i;
    adder_idx_o       = gnt_sb ? IDX_LEN'(sb_idx_i)
                               : IDX_LEN'(lb_idx_i);
  end

  // Steer adder results back to the issuing buffer.
  always_comb begin
    rsel              = adder_is_store_i ? sb_res_ready_i
                                         : lb_res_ready_i;
    lb_res_valid_o    = go & adder_res_valid_i & ~adder_is_store_i;
    sb_res_valid_o    = go & adder_res_valid_i & adder_is_store_i;
    adder_res_ready_o = rst_n_i & (~adder_res_valid_i | rsel);
    res_vaddr_o       = adder_vaddr_i;
    res_idx_o         = adder_idx_i;
    res_except_o      = adder_except_i;
  end

  // Next state: hold a stalled grant, rotate prio on transfer.
  always_comb begin
    state_d = IDLE;
    prio_d  = prio_q;
    if (!flush_i) begin
      if (xfer) begin
        prio_d = gnt_lb;
      end else if (gnt_lb) begin
        state_d = HOLD_LB;
      end else if (gnt_sb) begin
        state_d = HOLD_SB;
      end
    end
  end

  // State and priority registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_vaddr_adder_arbiter.sv
// tb_vaddr_adder_arbiter: directed + random checks of the
// LB/SB vaddr adder arbiter against a behavioural model.
module tb_vaddr_adder_arbiter;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        lb_valid, lb_ready, sb_valid, sb_ready;
  logic [31:0] lb_rs1, lb_imm, sb_rs1, sb_imm;
  logic [2:0]  lb_idx, sb_idx, lb_type, sb_type;
  logic        a_valid, a_ready, a_st;
  logic [31:0] a_rs1, a_imm;
  logic [2:0]  a_idx, a_type;
  logic        r_valid, r_ready, r_st;
  logic [31:0] r_vaddr;
  logic [2:0]  r_idx;
  except_code_t r_exc;
  logic        lb_rv, sb_rv, lb_rr, sb_rr;
  logic [31:0] o_vaddr;
  logic [2:0]  o_idx;
  except_code_t o_exc;

  int checks = 0;
  int errors = 0;

  int hold  = 0;
  bit mprio = 1'b0;

  always #5 clk = ~clk;

  vaddr_adder_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .lb_valid_i(lb_valid), .lb_ready_o(lb_ready),
    .lb_rs1_value_i(lb_rs1), .lb_imm_value_i(lb_imm),
    .lb_idx_i(lb_idx), .lb_ldst_type_i(lb_type),
    .sb_valid_i(sb_valid), .sb_ready_o(sb_ready),
    .sb_rs1_value_i(sb_rs1), .sb_imm_value_i(sb_imm),
    .sb_idx_i(sb_idx), .sb_ldst_type_i(sb_type),
    .adder_valid_o(a_valid), .adder_ready_i(a_ready),
    .adder_is_store_o(a_st), .adder_rs1_o(a_rs1),
    .adder_imm_o(a_imm), .adder_idx_o(a_idx),
    .adder_ldst_type_o(a_type),
    .adder_res_valid_i(r_valid), .adder_res_ready_o(r_ready),
    .adder_is_store_i(r_st), .adder_vaddr_i(r_vaddr),
    .adder_idx_i(r_idx), .adder_except_i(r_exc),
    .lb_res_valid_o(lb_rv), .sb_res_valid_o(sb_rv),
    .lb_res_ready_i(lb_rr), .sb_res_ready_i(sb_rr),
    .res_vaddr_o(o_vaddr), .res_idx_o(o_idx),
    .res_except_o(o_exc)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: g = 0 none, 1 LB, 2 SB; hold = side stuck behind a stall.
  always @(negedge clk) begin
    int g;
    bit go;
    go = rst_n && !flush;
    if (!rst_n) g = 0;
    else if (hold == 1) g = lb_valid ? 1 : 0;
    else if (hold == 2) g = sb_valid ? 2 : 0;
    else if (lb_valid && sb_valid) g = mprio ? 2 : 1;
    else g = lb_valid ? 1 : (sb_valid ? 2 : 0);
    chk("m_valid", 32'(a_valid), 32'(go && g != 0));
    chk("m_lb_ready", 32'(lb_ready), 32'(go && g == 1 && a_ready));
    chk("m_sb_ready", 32'(sb_ready), 32'(go && g == 2 && a_ready));
    if (go && g != 0) begin
      chk("m_is_store", 32'(a_st), 32'(g == 2));
      chk("m_rs1", a_rs1, g == 2 ? sb_rs1 : lb_rs1);
      chk("m_imm", a_imm, g == 2 ? sb_imm : lb_imm);
      chk("m_idx", 32'(a_idx), 32'(g == 2 ? sb_idx : lb_idx));
      chk("m_type", 32'(a_type), 32'(g == 2 ? sb_type : lb_type));
    end
    chk("m_lb_rv", 32'(lb_rv), 32'(go && r_valid && !r_st));
    chk("m_sb_rv", 32'(sb_rv), 32'(go && r_valid && r_st));
    chk("m_res_ready", 32'(r_ready),
        32'(rst_n && (!r_valid || (r_st ? sb_rr : lb_rr))));
    if (rst_n) begin
      chk("m_vaddr", o_vaddr, r_vaddr);
      chk("m_ridx", 32'(o_idx), 32'(r_idx));
      chk("m_exc", 32'(o_exc), 32'(r_exc));
    end
    if (!rst_n) begin
      hold  = 0;
      mprio = 1'b0;
    end else if (flush) begin
      hold = 0;
    end else if (g != 0 && a_ready) begin
      mprio = (g == 1);
      hold  = 0;
    end else begin
      hold = g;
    end
  end

  initial begin
    rst_n = 0; flush = 0;
    lb_valid = 0; sb_valid = 0; a_ready = 0;
    lb_rs1 = 0; lb_imm = 0; sb_rs1 = 0; sb_imm = 0;
    lb_idx = 0; sb_idx = 0; lb_type = 0; sb_type = 0;
    r_valid = 0; r_st = 0; r_vaddr = 0; r_idx = 0; r_exc = '0;
    lb_rr = 0; sb_rr = 0;

    @(negedge clk);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_lb_ready", 32'(lb_ready), 0);
    chk("rst_sb_ready", 32'(sb_ready), 0);
    chk("rst_res_ready", 32'(r_ready), 0);

    cyc();
    rst_n = 1; lb_valid = 1; a_ready = 1; lb_idx = 3'd5;
    @(negedge clk);
    chk("t1_is_store", 32'(a_st), 0);
    chk("t1_lb_ready", 32'(lb_ready), 1);
    chk("t1_idx", 32'(a_idx), 5);

    cyc(); rst_n = 0; lb_valid = 0;
    cyc(); rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      lb_valid = 1; sb_valid = 1; a_ready = 1;
      lb_idx = 3'(i); sb_idx = 3'(7 - i);
      @(negedge clk);
      chk("t2_is_store", 32'(a_st), 32'(i % 2));
      chk("t2_idx", 32'(a_idx), (i % 2) ? 32'(7 - i) : 32'(i));
      cyc();
    end

    @(negedge clk);
    chk("t3_pre_lb", 32'(a_st), 0);
    cyc(); a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_st", 32'(a_st), 1);
      chk("t3_hold_valid", 32'(a_valid), 1);
      chk("t3_hold_lbr", 32'(lb_ready), 0);
      cyc();
    end
    a_ready = 1;
    @(negedge clk);
    chk("t3_sb_xfer", 32'(sb_ready), 1);
    chk("t3_lb_blocked", 32'(lb_ready), 0);
    cyc();
    @(negedge clk);
    chk("t3_next_lb", 32'(a_st), 0);
    chk("t3_next_lbr", 32'(lb_ready), 1);
    cyc();

    lb_valid = 0; sb_valid = 0;
    r_valid = 1; r_st = 1; r_vaddr = 32'h1000; lb_rr = 1; sb_rr = 0;
    @(negedge clk);
    chk("t4_sb_rv", 32'(sb_rv), 1);
    chk("t4_lb_rv", 32'(lb_rv), 0);
    chk("t4_res_ready", 32'(r_ready), 0);
    chk("t4_vaddr", o_vaddr, 32'h1000);
    cyc(); sb_rr = 1;
    @(negedge clk);
    chk("t4_res_ready1", 32'(r_ready), 1);
    cyc(); r_valid = 0;

    lb_valid = 1; a_ready = 0;
    @(negedge clk);
    chk("t5_lb_grant", 32'(a_valid && !a_st), 1);
    cyc(); sb_valid = 1; flush = 1; a_ready = 1;
    @(negedge clk);
    chk("t5_flush_valid", 32'(a_valid), 0);
    chk("t5_flush_lbr", 32'(lb_ready), 0);
    cyc(); flush = 0;
    @(negedge clk);
    chk("t5_prio_kept", 32'(a_st), 1);
    cyc();

    lb_valid = 0; sb_valid = 1; a_ready = 0;
    @(negedge clk);
    chk("t6_sb_grant", 32'(a_st), 1);
    cyc();
    a_ready = 1; rst_n = 0;
    #1;
    chk("t6_rst_valid", 32'(a_valid), 0);
    chk("t6_rst_sbr", 32'(sb_ready), 0);
    cyc();
    rst_n = 1; lb_valid = 1; sb_valid = 1; a_ready = 1;
    @(negedge clk);
    chk("t6_lb_wins", 32'(a_st), 0);
    chk("t6_lb_ready", 32'(lb_ready), 1);
    cyc();

    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      lb_valid = ($urandom_range(0, 3) != 0);
      sb_valid = ($urandom_range(0, 3) != 0);
      a_ready  = ($urandom_range(0, 2) != 0);
      lb_rs1 = $urandom; lb_imm = $urandom;
      sb_rs1 = $urandom; sb_imm = $urandom;
      lb_idx = 3'($urandom_range(0, 7));
      sb_idx = 3'($urandom_range(0, 7));
      lb_type = 3'($urandom_range(0, 7));
      sb_type = 3'($urandom_range(0, 7));
      r_valid = $urandom_range(0, 1);
      r_st    = $urandom_range(0, 1);
      r_vaddr = $urandom;
      r_idx   = 3'($urandom_range(0, 7));
      r_exc   = except_code_t'($urandom_range(0, 15));
      lb_rr   = $urandom_range(0, 1);
      sb_rr   = $urandom_range(0, 1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
